// File: rtl/ama_riscv_trace_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_trace_pipe_if
// Brief    : Trace record valid/ready channel between tracker and consumer
// Revision : 1.0 - initial release
// ============================================================================
interface ama_riscv_trace_pipe_if #(
    parameter int REC_WIDTH = 103
) ();
    logic                 trace_valid;
    logic                 trace_ready;
    logic [REC_WIDTH-1:0] trace_rec;

    modport master (
        output trace_valid,
        output trace_rec,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_rec,
        output trace_ready
    );
endinterface
`default_nettype wire

// File: rtl/ama_riscv_trace_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_trace_pipe
// Brief    : Retire-trace tracker: EXE side info through N stages into a
//            trace FIFO with retire/bubble/drop statistics.
//            Optional feature macro: AMA_TRACE_BP_EN (tracks bp_hit).
// Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_trace_pipe #(
    parameter int N_STAGES   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int ARCH_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic [N_STAGES-1:0]               stage_en,
    input  wire logic [N_STAGES-1:0]               stage_flush,
    input  wire logic                              exe_branch_inst,
    input  wire logic                              exe_branch_taken,
    input  wire logic                              exe_bp_hit,
    input  wire logic                              exe_dmem_valid,
    input  wire logic [ARCH_WIDTH-1:0]             exe_dmem_addr,
    input  wire logic [2:0]                        exe_dmem_size,
    input  wire logic                              exe_bubble,
    input  wire logic                              inst_retired,
    input  wire logic [INST_WIDTH-1:0]             inst_wbk,
    input  wire logic [ARCH_WIDTH-1:0]             pc_wbk,
    ama_riscv_trace_pipe_if.master                 trace_if,
    output logic [CNT_WIDTH-1:0]                   retired_cnt,
    output logic [CNT_WIDTH-1:0]                   bubble_cnt,
    output logic [CNT_WIDTH-1:0]                   drop_cnt,
    output logic                                   overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level
);

    localparam int REC_W = INST_WIDTH + 2*ARCH_WIDTH + 7;
    localparam int SW    = ARCH_WIDTH + 7;
    localparam int AW    = $clog2(FIFO_DEPTH);

    // Stage layout: {branch_inst, branch_taken, dmem_addr, dmem_size[3:0], bubble}
    localparam logic [SW-1:0] c_EMPTY = {1'b0, 1'b0, {ARCH_WIDTH{1'b0}}, 4'd8, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [AW:0]          c_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [SW-1:0] w_cap;
    logic [SW-1:0] r_stage [N_STAGES];
    logic [SW-1:0] w_last;
    logic          w_last_bp;

    assign w_cap = {exe_branch_inst,
                    exe_branch_taken & exe_branch_inst,
                    exe_dmem_valid ? exe_dmem_addr : {ARCH_WIDTH{1'b0}},
                    exe_dmem_valid ? {1'b0, exe_dmem_size} : 4'd8,
                    exe_bubble};

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        logic [SW-1:0] w_src;
        if (k == 0) begin : g_head
            assign w_src = w_cap;
        end else begin : g_tail
            assign w_src = r_stage[k-1];
        end

        always_ff @(posedge clk) begin
            if (rst || stage_flush[k]) begin
                r_stage[k] <= c_EMPTY;
            end else if (stage_en[k]) begin
                r_stage[k] <= w_src;
            end
        end
    end

`ifdef AMA_TRACE_BP_EN
    logic r_bp [N_STAGES];

    for (genvar k = 0; k < N_STAGES; k++) begin : g_bp
        logic w_src;
        if (k == 0) begin : g_head
            assign w_src = exe_bp_hit & exe_branch_inst;
        end else begin : g_tail
            assign w_src = r_bp[k-1];
        end

        always_ff @(posedge clk) begin
            if (rst || stage_flush[k]) begin
                r_bp[k] <= 1'b0;
            end else if (stage_en[k]) begin
                r_bp[k] <= w_src;
            end
        end
    end

    assign w_last_bp = r_bp[N_STAGES-1];
`else
    logic w_unused_bp;
    assign w_unused_bp = exe_bp_hit;
    assign w_last_bp   = 1'b0;
`endif

    assign w_last = r_stage[N_STAGES-1];

    logic [REC_W-1:0] w_rec;
    assign w_rec = {inst_wbk, pc_wbk, w_last[ARCH_WIDTH+4:5], w_last[4:1],
                    w_last[ARCH_WIDTH+6], w_last[ARCH_WIDTH+5], w_last_bp};

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [REC_W-1:0] r_mem [FIFO_DEPTH];
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW:0]      w_level;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && trace_if.trace_ready;
    assign w_push  = inst_retired && (!w_full || w_pop);
    assign w_drop  = inst_retired && w_full && !w_pop;
    assign w_level = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
        end
    end

    logic [CNT_WIDTH-1:0] r_retired_cnt;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic                 r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_retired_cnt <= '0;
            r_bubble_cnt  <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (inst_retired) begin
                r_retired_cnt <= r_retired_cnt + c_CNT_ONE;
            end else if (w_last[0]) begin
                r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {CNT_WIDTH{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign trace_if.trace_valid = !w_empty;
    assign trace_if.trace_rec   = r_mem[r_rd_ptr[AW-1:0]];
    assign retired_cnt          = r_retired_cnt;
    assign bubble_cnt           = r_bubble_cnt;
    assign drop_cnt             = r_drop_cnt;
    assign overflow             = r_overflow;
    assign fifo_level           = w_level;

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_trace_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ama_riscv_trace_pipe
// Brief    : Directed self-checking bench for ama_riscv_trace_pipe
//            (N_STAGES=2, FIFO_DEPTH=8); honours AMA_TRACE_BP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_trace_pipe;

    localparam int REC_W = 103;
`ifdef AMA_TRACE_BP_EN
    localparam logic c_EXP_BP = 1'b1;
`else
    localparam logic c_EXP_BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        r_rst = 1'b1;
    logic [1:0]  r_stage_en = 2'b11;
    logic [1:0]  r_stage_flush = 2'b00;
    logic        r_br = 1'b0, r_taken = 1'b0, r_bp = 1'b0;
    logic        r_dv = 1'b0;
    logic [31:0] r_daddr = '0;
    logic [2:0]  r_dsize = '0;
    logic        r_bubble = 1'b0;
    logic        r_ret = 1'b0;
    logic [31:0] r_inst = '0;
    logic [31:0] r_pc = '0;
    logic [31:0] w_retired, w_bubbles, w_drops;
    logic        w_ovf;
    logic [3:0]  w_level;

    int n_total = 0;
    int n_bad   = 0;

    ama_riscv_trace_pipe_if #(.REC_WIDTH(REC_W)) u_trace_if ();

    ama_riscv_trace_pipe #(
        .N_STAGES(2), .FIFO_DEPTH(8), .ARCH_WIDTH(32), .INST_WIDTH(32), .CNT_WIDTH(32)
    ) u_dut (
        .clk(clk), .rst(r_rst),
        .stage_en(r_stage_en), .stage_flush(r_stage_flush),
        .exe_branch_inst(r_br), .exe_branch_taken(r_taken), .exe_bp_hit(r_bp),
        .exe_dmem_valid(r_dv), .exe_dmem_addr(r_daddr), .exe_dmem_size(r_dsize),
        .exe_bubble(r_bubble),
        .inst_retired(r_ret), .inst_wbk(r_inst), .pc_wbk(r_pc),
        .trace_if(u_trace_if),
        .retired_cnt(w_retired), .bubble_cnt(w_bubbles), .drop_cnt(w_drops),
        .overflow(w_ovf), .fifo_level(w_level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] inst, input logic [31:0] pc,
                                                 input logic [31:0] addr, input logic [3:0] size,
                                                 input logic bi, input logic bt, input logic bp);
        return {inst, pc, addr, size, bi, bt, bp};
    endfunction

    function automatic logic [31:0] rec_pc(input logic [REC_W-1:0] rec);
        return rec[70:39];
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"},   u_trace_if.trace_valid, 1'b0);
        check_eq({tag, "_level"},   w_level, 4'd0);
        check_eq({tag, "_retired"}, w_retired, 32'd0);
        check_eq({tag, "_bubble"},  w_bubbles, 32'd0);
        check_eq({tag, "_drop"},    w_drops, 32'd0);
        check_eq({tag, "_ovf"},     w_ovf, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        u_trace_if.trace_ready = 1'b1;

        // Reset
        tick();
        tick();
        check_idle("reset");
        r_rst = 1'b0;

        // Branch taken captured, retired two enabled edges later
        r_br = 1'b1; r_taken = 1'b1; r_bp = 1'b1;
        tick();
        r_br = 1'b0; r_taken = 1'b0; r_bp = 1'b0;
        tick();
        r_ret = 1'b1; r_inst = 32'h0000_0063; r_pc = 32'h0000_0100;
        tick();
        r_ret = 1'b0;
        check_eq("br_valid", u_trace_if.trace_valid, 1'b1);
        check_eq("br_rec", u_trace_if.trace_rec,
                 mk_rec(32'h0000_0063, 32'h100, 32'h0, 4'd8, 1'b1, 1'b1, c_EXP_BP));
        check_eq("br_retired", w_retired, 32'd1);
        check_eq("br_bubble", w_bubbles, 32'd2);
        check_eq("br_level", w_level, 4'd1);
        tick();
        check_eq("br_popped", u_trace_if.trace_valid, 1'b0);

        // Store record, then a non-access record with a masked address
        r_dv = 1'b1; r_daddr = 32'h8000_1004; r_dsize = 3'd6;
        tick();
        r_dv = 1'b0; r_daddr = 32'hDEAD_BEEF;
        tick();
        r_ret = 1'b1; r_inst = 32'h0011_2023; r_pc = 32'h0000_0104;
        tick();
        check_eq("st_rec", u_trace_if.trace_rec,
                 mk_rec(32'h0011_2023, 32'h104, 32'h8000_1004, 4'd6, 1'b0, 1'b0, 1'b0));
        r_inst = 32'h0000_0013; r_pc = 32'h0000_0108;
        tick();
        r_ret = 1'b0; r_daddr = '0; r_dsize = '0;
        check_eq("na_rec", u_trace_if.trace_rec,
                 mk_rec(32'h0000_0013, 32'h108, 32'h0, 4'd8, 1'b0, 1'b0, 1'b0));
        check_eq("na_level", w_level, 4'd1);
        tick();

        // Stall stage 1, then flush it into a bubble
        r_stage_en = 2'b01;
        tick(); tick(); tick();
        check_eq("stall_bubble", w_bubbles, 32'd2);
        r_stage_flush = 2'b10;
        tick();
        r_stage_flush = 2'b00;
        tick();
        check_eq("flush_bubble1", w_bubbles, 32'd3);
        tick(); tick();
        check_eq("flush_bubble3", w_bubbles, 32'd5);
        r_ret = 1'b1; r_inst = 32'h0000_0033; r_pc = 32'h0000_010C;
        tick();
        r_ret = 1'b0; r_stage_en = 2'b11;
        check_eq("bub_ret_rec", u_trace_if.trace_rec,
                 mk_rec(32'h0000_0033, 32'h10C, 32'h0, 4'd8, 1'b0, 1'b0, 1'b0));
        check_eq("bub_ret_retired", w_retired, 32'd4);
        check_eq("bub_ret_bubble", w_bubbles, 32'd5);
        tick();
        check_eq("bub_after", w_bubbles, 32'd6);

        // Backpressure: ten retirements into an eight-entry FIFO
        u_trace_if.trace_ready = 1'b0;
        r_ret = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r_pc = 32'h200 + 32'(4 * i);
            tick();
        end
        r_ret = 1'b0;
        check_eq("bp_level", w_level, 4'd8);
        check_eq("bp_drop", w_drops, 32'd2);
        check_eq("bp_ovf", w_ovf, 1'b1);
        check_eq("bp_retired", w_retired, 32'd14);
        check_eq("bp_head", rec_pc(u_trace_if.trace_rec), 32'h200);
        tick();
        check_eq("bp_hold_head", rec_pc(u_trace_if.trace_rec), 32'h200);
        check_eq("bp_hold_valid", u_trace_if.trace_valid, 1'b1);

        // Full with simultaneous push and pop
        u_trace_if.trace_ready = 1'b1;
        r_ret = 1'b1; r_pc = 32'h300;
        tick();
        r_ret = 1'b0;
        check_eq("pp_level", w_level, 4'd8);
        check_eq("pp_drop", w_drops, 32'd2);
        for (int i = 1; i < 5; i++) begin
            check_eq("drain_pc", rec_pc(u_trace_if.trace_rec), 32'h200 + 32'(4 * i));
            tick();
        end
        check_eq("drain_level", w_level, 4'd4);

        // Reset mid-stream
        r_rst = 1'b1; r_ret = 1'b1;
        tick();
        r_rst = 1'b0; r_ret = 1'b0;
        check_idle("midrst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
